stream_convolution: RTL and testbench
=====================================

# stream_convolution

Streaming 2-D convolution engine: accepts a raster-order pixel stream of one IMAGE_HEIGHT × IMAGE_WIDTH frame and emits one convolution result per pixel in the same raster order. It applies zero padding on all four image borders. It buffers KERNEL_SIZE rows internally, uses valid/ready handshakes on both streams, and takes a kernel written through a register port while idle. It is the frame-level successor of the single-row-window combinational convolver and sits between the pixel source and the feature-map writer.

## Interface
- KERNEL_SIZE, 3: kernel side length; must be odd and ≥ 3; P = KERNEL_SIZE/2.
- IMAGE_WIDTH, 4: pixels per row; must be ≥ KERNEL_SIZE.
- IMAGE_HEIGHT, 4: rows per frame; must be ≥ KERNEL_SIZE.
- DATA_W, 8: unsigned pixel width.
- COEF_W, 16: coefficient width.
- OUT_W, 32: result width; results truncate to the low OUT_W bits.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coef_we  in  1  coefficient write strobe; honoured only in IDLE.
- coef_row  in  $clog2(KERNEL_SIZE)  kernel row index.
- coef_col  in  $clog2(KERNEL_SIZE)  kernel column index.
- coef_data  in  COEF_W  coefficient value.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  pixel stream.
- out_valid / out_ready / out_data  out / in / out  1 / 1 / OUT_W  result stream.

## Operation
- Reset: all outputs are 0. State goes to IDLE, and the pixel and row counters clear. The coefficient RAM is reset to all-zero. A reset mid-frame discards the frame; no partial result is emitted after reset.
- FSM:
  - IDLE: start moves to RUN.
  - RUN: on accepting the last input pixel (row H-1, col W-1), moves to FLUSH.
  - FLUSH: on the handshake of the last output (row H-1, col W-1), moves to IDLE.
- Coefficient writes outside IDLE are ignored. A write and start in the same IDLE cycle: the write takes effect and start is honoured.
- in_ready = (state == RUN) && output slot free.
- Result definition: result(r,c) = Σ over k,l ∈ [-P,P] of pix(r+k, c+l) × coef[P+k][P+l]. Out-of-frame pixels read as 0 on all four borders.
- Dependency rule: result(r,c) becomes computable once pixel (min(r+P,H-1), min(c+P,W-1)) has been accepted.
  - In RUN, each accepted pixel releases at most one result, in raster order.
  - The remaining P·W+P results are produced in FLUSH at one per cycle, with in_ready held low.
- Line buffer: KERNEL_SIZE rows × IMAGE_WIDTH, circular. Row index wraps modulo KERNEL_SIZE.
- Arithmetic:
  - Products are DATA_W+COEF_W bits.
  - The sum is accumulated at full width DATA_W+COEF_W+2·$clog2(KERNEL_SIZE) bits, then truncated to OUT_W.
  - Default interpretation: pixels and coefficients unsigned.
- Output register: one-entry skid. out_data and out_valid hold stable until out_ready is seen.
- Inputs with in_valid high while in_ready is low are not consumed.

## Timing
- Latency: out_valid rises 2 cycles after the handshake cycle of the enabling pixel.
  - Cycle 1: window MAC registered.
  - Cycle 2: output register loaded.
- Throughput: 1 pixel/cycle in RUN and 1 result/cycle in FLUSH when out_ready stays high.
- Backpressure: while out_valid && !out_ready and the MAC stage is full, in_ready is low in the same cycle. No result is dropped or duplicated.
- busy rises the cycle after start is accepted. It falls the cycle after the final output handshake.
- Frame length is exactly H·W inputs and H·W outputs. start during RUN or FLUSH is ignored.

## Configuration
- CONV_SIGNED_COEF_EN
  - Defined: coefficients are two's-complement signed, and pixels are zero-extended unsigned. The accumulator is signed and sign-extended before truncation to OUT_W.
  - Undefined: coefficients are unsigned and out_data is an unsigned sum.

## Test plan
- Identity kernel (centre = 1, all others 0), 4×4 frame with pixels 1..16 in raster order, out_ready held high -> out_data = 1..16 in order, first out_valid 2 cycles after pixel 6 (row 1, col 1) is accepted.
- All-ones kernel, 4×4 frame of all 1s -> corner results 4, edge results 6, interior results 9. Exactly 16 outputs, then busy = 0.
- Same frame as the all-ones case with out_ready toggled on a 1-on/2-off pattern -> identical 16 values in order, no duplicates, and in_ready low whenever the skid and MAC stages are full.
- Assert rst during row 2 of a frame, then rerun the identity frame -> out_valid = 0 and busy = 0 the cycle after reset. Every coefficient is 0 after reset, so the rerun reloads the centre coefficient = 1 before start. The rerun yields 1..16.
- Write coef[1][1] = 7 during RUN -> the write is ignored and results still match the previously loaded kernel.
- Centre coefficient 0xFFFF, all others 0, pixel 5:
  - With CONV_SIGNED_COEF_EN defined -> out_data = 0xFFFFFFFB (-5).
  - With CONV_SIGNED_COEF_EN undefined -> out_data = 0x0004FFFB (327675).

Source files
------------

// File: rtl/stream_convolution.sv
// stream_convolution: streaming KERNEL_SIZE x KERNEL_SIZE convolution over one
// raster-order frame with zero padding on all borders, a circular line buffer
// of KERNEL_SIZE rows, a registered MAC stage and a one-entry output skid.
// Optional feature macro CONV_SIGNED_COEF_EN: when defined, coefficients are
// two's-complement and the accumulator is sign-extended to OUT_W; otherwise
// everything is unsigned.
module stream_convolution #(
   parameter int KERNEL_SIZE  = 3,
   parameter int IMAGE_WIDTH  = 4,
   parameter int IMAGE_HEIGHT = 4,
   parameter int DATA_W       = 8,
   parameter int COEF_W       = 16,
   parameter int OUT_W        = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           coef_we,
   input  logic [$clog2(KERNEL_SIZE)-1:0] coef_row,
   input  logic [$clog2(KERNEL_SIZE)-1:0] coef_col,
   input  logic [COEF_W-1:0]              coef_data,
   input  logic                           start,
   output logic                           busy,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_W-1:0]               out_data
);

   localparam int P      = KERNEL_SIZE / 2;
   localparam int IDX_W  = $clog2(KERNEL_SIZE);
   localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
   localparam int COL_W  = $clog2(IMAGE_WIDTH);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + 2 * IDX_W;
   localparam int EXT_W  = (OUT_W > ACC_W) ? OUT_W : ACC_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t stateQ, stateD;

   logic [COEF_W-1:0] coefQ    [KERNEL_SIZE][KERNEL_SIZE];
   logic [DATA_W-1:0] lineBufQ [KERNEL_SIZE][IMAGE_WIDTH];

   logic [ROW_W-1:0] inRowQ, resRowQ;
   logic [COL_W-1:0] inColQ, resColQ;
   logic [IDX_W-1:0] inSlotQ, resSlotQ;
   logic             resDoneQ;

   logic             macVldQ, macLastQ;
   logic [OUT_W-1:0] macDataQ;
   logic             outVldQ, outLastQ;
   logic [OUT_W-1:0] outDataQ;

   logic inHs, outHs, macAdv, loadOut;
   logic inLast, resLast, primed, tokValid;

   int               winRow, winCol, winSlot;
   logic [DATA_W-1:0] winPix;
   logic [EXT_W-1:0]  winExt;
   logic [OUT_W-1:0]  winSum;
`ifdef CONV_SIGNED_COEF_EN
   localparam int SPROD_W = PROD_W + 1;
   logic signed [SPROD_W-1:0] winProd;
   logic signed [ACC_W-1:0]   winAcc;
`else
   logic [PROD_W-1:0] winProd;
   logic [ACC_W-1:0]  winAcc;
`endif

   // The MAC stage may advance when it is empty or its result can move on to
   // the skid register; pixels are only taken when the MAC can accept a token.
   assign macAdv   = !macVldQ || !outVldQ || out_ready;
   assign in_ready = (stateQ == RUN) && macAdv;
   assign inHs     = in_valid && in_ready;
   assign outHs    = outVldQ && out_ready;
   assign loadOut  = macVldQ && (!outVldQ || out_ready);

   assign inLast  = (int'(inRowQ) == IMAGE_HEIGHT - 1) && (int'(inColQ) == IMAGE_WIDTH - 1);
   assign resLast = (int'(resRowQ) == IMAGE_HEIGHT - 1) && (int'(resColQ) == IMAGE_WIDTH - 1);

   // Once P*W+P pixels have arrived every further pixel releases exactly one
   // result; the remaining P*W+P results drain during FLUSH.
   assign primed   = (int'(inRowQ) > P) || ((int'(inRowQ) == P) && (int'(inColQ) >= P));
   assign tokValid = (inHs && primed) || ((stateQ == FLUSH) && macAdv && !resDoneQ);

   assign busy      = (stateQ != IDLE);
   assign out_valid = outVldQ;
   assign out_data  = outDataQ;

   // Frame control state register.
   always_ff @(posedge clk) begin
      if (rst) stateQ <= IDLE;
      else     stateQ <= stateD;
   end

   // Frame control next-state: IDLE -> RUN on start, RUN -> FLUSH after the
   // last pixel, FLUSH -> IDLE once the last result has been handed off.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (start) stateD = RUN;
         RUN:     if (inHs && inLast) stateD = FLUSH;
         FLUSH:   if (outHs && outLastQ) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Coefficient RAM: cleared by reset, writable only while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < KERNEL_SIZE; i++)
            for (int j = 0; j < KERNEL_SIZE; j++)
               coefQ[i][j] <= '0;
      end else if ((stateQ == IDLE) && coef_we &&
                   (int'(coef_row) < KERNEL_SIZE) && (int'(coef_col) < KERNEL_SIZE)) begin
         coefQ[coef_row][coef_col] <= coef_data;
      end
   end

   // Pixel and result raster counters, with the line-buffer slot of each row.
   always_ff @(posedge clk) begin
      if (rst) begin
         inRowQ   <= '0;
         inColQ   <= '0;
         inSlotQ  <= '0;
         resRowQ  <= '0;
         resColQ  <= '0;
         resSlotQ <= '0;
         resDoneQ <= 1'b0;
      end else if ((stateQ == IDLE) && start) begin
         inRowQ   <= '0;
         inColQ   <= '0;
         inSlotQ  <= '0;
         resRowQ  <= '0;
         resColQ  <= '0;
         resSlotQ <= '0;
         resDoneQ <= 1'b0;
      end else begin
         if (inHs) begin
            if (int'(inColQ) == IMAGE_WIDTH - 1) begin
               inColQ  <= '0;
               inRowQ  <= inRowQ + 1'b1;
               inSlotQ <= (int'(inSlotQ) == KERNEL_SIZE - 1) ? '0 : inSlotQ + 1'b1;
            end else begin
               inColQ <= inColQ + 1'b1;
            end
         end
         if (tokValid) begin
            if (resLast) resDoneQ <= 1'b1;
            if (int'(resColQ) == IMAGE_WIDTH - 1) begin
               resColQ  <= '0;
               resRowQ  <= resRowQ + 1'b1;
               resSlotQ <= (int'(resSlotQ) == KERNEL_SIZE - 1) ? '0 : resSlotQ + 1'b1;
            end else begin
               resColQ <= resColQ + 1'b1;
            end
         end
      end
   end

   // Circular line buffer; row r lives in slot r mod KERNEL_SIZE.
   always_ff @(posedge clk) begin
      if (inHs) lineBufQ[inSlotQ][inColQ] <= in_data;
   end

   // Window MAC for the next result; out-of-frame taps read as zero and the
   // pixel being accepted this cycle is bypassed straight from in_data.
   always_comb begin
      winRow  = 0;
      winCol  = 0;
      winSlot = 0;
      winPix  = '0;
      winProd = '0;
      winAcc  = '0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
         for (int l = 0; l < KERNEL_SIZE; l++) begin
            winRow  = int'(resRowQ) + k - P;
            winCol  = int'(resColQ) + l - P;
            winSlot = int'(resSlotQ) + k - P;
            if (winSlot < 0) winSlot = winSlot + KERNEL_SIZE;
            else if (winSlot >= KERNEL_SIZE) winSlot = winSlot - KERNEL_SIZE;
            winPix = '0;
            if ((winRow >= 0) && (winRow < IMAGE_HEIGHT) && (winCol >= 0) && (winCol < IMAGE_WIDTH)) begin
               if (inHs && (winSlot == int'(inSlotQ)) && (winCol == int'(inColQ)))
                  winPix = in_data;
               else
                  winPix = lineBufQ[winSlot[IDX_W-1:0]][winCol[COL_W-1:0]];
            end
`ifdef CONV_SIGNED_COEF_EN
            winProd = SPROD_W'($signed({1'b0, winPix})) * SPROD_W'($signed(coefQ[k][l]));
`else
            winProd = PROD_W'(winPix) * PROD_W'(coefQ[k][l]);
`endif
            winAcc = winAcc + ACC_W'(winProd);
         end
      end
      winExt = EXT_W'(winAcc);
   end

   assign winSum = winExt[OUT_W-1:0];

   // MAC register followed by the one-entry output skid; a stalled result
   // stays in the MAC register until the skid drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         macVldQ  <= 1'b0;
         macLastQ <= 1'b0;
         macDataQ <= '0;
         outVldQ  <= 1'b0;
         outLastQ <= 1'b0;
         outDataQ <= '0;
      end else begin
         if (macAdv) begin
            macVldQ  <= tokValid;
            macLastQ <= tokValid && resLast;
            if (tokValid) macDataQ <= winSum;
         end
         if (loadOut) begin
            outVldQ  <= 1'b1;
            outLastQ <= macLastQ;
            outDataQ <= macDataQ;
         end else if (outHs) begin
            outVldQ <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_convolution.sv
// tb_stream_convolution: directed frames against a per-pixel convolution
// model kept as a scoreboard queue, with literal pins on the model itself.
module tb_stream_convolution;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        coef_we;
   logic [1:0]  coef_row, coef_col;
   logic [15:0] coef_data;
   logic        start;
   logic        busy;
   logic        in_valid, in_ready;
   logic [7:0]  in_data;
   logic        out_valid, out_ready;
   logic [31:0] out_data;

   logic [15:0] kern [3][3];
   int          img  [W*H];
   logic [31:0] expQ [$];

   int nVectors = 0;
   int nMis     = 0;
   int cycleCnt = 0;
   int readyMode = 0;
   int inCnt, outCnt, hs5Cycle, firstOut;
   bit prevStall = 1'b0;
   logic [31:0] prevData;

   stream_convolution dut (
      .clk       (clk),
      .rst       (rst),
      .coef_we   (coef_we),
      .coef_row  (coef_row),
      .coef_col  (coef_col),
      .coef_data (coef_data),
      .start     (start),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt++;

   // out_ready either held high or pulsed one cycle in three.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (readyMode == 0) ? 1'b1 : ((cycleCnt % 3) == 0);
      end
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nVectors++;
      if (act !== expv) begin
         nMis++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Convolution of the current image with the current kernel at (r,c).
   function automatic logic [31:0] model(input int r, input int c);
      longint sum = 0;
      longint cv;
      for (int k = -1; k <= 1; k++) begin
         for (int l = -1; l <= 1; l++) begin
            if ((r + k >= 0) && (r + k < H) && (c + l >= 0) && (c + l < W)) begin
`ifdef CONV_SIGNED_COEF_EN
               cv = longint'($signed(kern[k+1][l+1]));
`else
               cv = longint'(kern[k+1][l+1]);
`endif
               sum += longint'(img[(r + k) * W + (c + l)]) * cv;
            end
         end
      end
      return sum[31:0];
   endfunction

   task automatic writeCoef(input int r, input int c, input logic [15:0] v);
      coef_we   = 1'b1;
      coef_row  = 2'(r);
      coef_col  = 2'(c);
      coef_data = v;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic loadKernel();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            writeCoef(r, c, kern[r][c]);
   endtask

   task automatic setKernel(input int a00, input int a01, input int a02, input int a10, input int a11,
                            input int a12, input int a20, input int a21, input int a22);
      kern[0][0] = 16'(a00); kern[0][1] = 16'(a01); kern[0][2] = 16'(a02);
      kern[1][0] = 16'(a10); kern[1][1] = 16'(a11); kern[1][2] = 16'(a12);
      kern[2][0] = 16'(a20); kern[2][1] = 16'(a21); kern[2][2] = 16'(a22);
   endtask

   // Presents one pixel and holds it until the DUT takes it (bounded).
   task automatic applyStimulus(input logic [7:0] d);
      int tries = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
         tries++;
         if (tries > 200) begin
            checkOutput("inputStall", 32'(in_ready), 32'd1);
            return;
         end
      end
   endtask

   // Runs one complete frame and checks its end-of-frame conditions.
   task automatic runFrame(input int mode, input bit midWrite, input bit coefWithStart, input bit checkLat);
      int guard;
      readyMode = mode;
      inCnt = 0; outCnt = 0; hs5Cycle = -1; firstOut = -1;
      for (int i = 0; i < W*H; i++) expQ.push_back(model(i / W, i % W));
      start = 1'b1;
      if (coefWithStart) begin
         coef_we = 1'b1; coef_row = 2'd1; coef_col = 2'd1; coef_data = kern[1][1];
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      coef_we = 1'b0;
      for (int i = 0; i < W*H; i++) begin
         if (midWrite && (i == 6)) begin
            coef_we = 1'b1; coef_row = 2'd1; coef_col = 2'd1; coef_data = 16'd7; start = 1'b1;
         end
         applyStimulus(8'(img[i]));
         coef_we = 1'b0;
         start = 1'b0;
      end
      in_valid = 1'b0;
      guard = 0;
      while (((expQ.size() != 0) || busy) && (guard < 500)) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      checkOutput("frameBusy", 32'(busy), 32'd0);
      checkOutput("frameOutCount", 32'(outCnt), 32'(W*H));
      checkOutput("frameInCount", 32'(inCnt), 32'(W*H));
      checkOutput("frameQueue", 32'(expQ.size()), 32'd0);
      if (checkLat) checkOutput("firstLatency", 32'(firstOut - hs5Cycle), 32'd2);
      @(posedge clk);
      #1;
      readyMode = 0;
   endtask

   // Compare process: scoreboard on every output handshake, hold-while-stalled
   // checks, and no input acceptance while idle.
   always @(negedge clk) begin
      if (rst) begin
         prevStall = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            if (inCnt == 5) hs5Cycle = cycleCnt;
            inCnt++;
         end
         if (out_valid && (firstOut < 0)) firstOut = cycleCnt;
         if (prevStall) begin
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdData", out_data, prevData);
         end
         if (out_valid && out_ready) begin
            outCnt++;
            if (expQ.size() == 0) begin
               nVectors++;
               nMis++;
               $display("[TB] FAIL extraOutput: got 0x%08h, expected no output", out_data);
            end else begin
               checkOutput("outData", out_data, expQ.pop_front());
            end
         end
         if (!busy) checkOutput("idleInReady", 32'(in_ready), 32'd0);
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
      end
   end

   initial begin
      rst = 1'b1; coef_we = 1'b0; coef_row = '0; coef_col = '0; coef_data = '0;
      start = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstInReady", 32'(in_ready), 32'd0);
      checkOutput("rstData", out_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Identity kernel over pixels 1..16.
      for (int i = 0; i < W*H; i++) img[i] = i + 1;
      setKernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("modelIdentity12", model(1, 2), 32'd7);
      checkOutput("modelIdentity33", model(3, 3), 32'd16);
      loadKernel();
      runFrame(0, 1'b0, 1'b0, 1'b1);

      // All-ones kernel over an all-ones frame.
      for (int i = 0; i < W*H; i++) img[i] = 1;
      setKernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
      checkOutput("modelCorner", model(0, 0), 32'd4);
      checkOutput("modelEdge", model(0, 2), 32'd6);
      checkOutput("modelInterior", model(2, 1), 32'd9);
      checkOutput("modelCorner33", model(3, 3), 32'd4);
      loadKernel();
      runFrame(0, 1'b0, 1'b0, 1'b1);

      // Same frame under 1-on/2-off backpressure.
      runFrame(1, 1'b0, 1'b0, 1'b1);

      // Reset in row 2 of a frame, then rerun identity with only the centre reloaded.
      for (int i = 0; i < W*H; i++) img[i] = i + 1;
      for (int i = 0; i < W*H; i++) expQ.push_back(model(i / W, i % W));
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 9; i++) applyStimulus(8'(img[i]));
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRstValid", 32'(out_valid), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      expQ.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      setKernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
      writeCoef(1, 1, 16'd1);
      runFrame(0, 1'b0, 1'b0, 1'b1);

      // Graded kernel; a write and a start during RUN must both be ignored.
      setKernel(1, 2, 3, 4, 5, 6, 7, 8, 9);
      checkOutput("modelGraded00", model(0, 0), 32'd111);
      loadKernel();
      runFrame(1, 1'b1, 1'b0, 1'b1);

      // Centre 0xFFFF written in the same cycle as start, frame of all 5s.
      for (int i = 0; i < W*H; i++) img[i] = 5;
      setKernel(0, 0, 0, 0, 0, 0, 0, 0, 0);
      loadKernel();
      kern[1][1] = 16'hFFFF;
`ifdef CONV_SIGNED_COEF_EN
      checkOutput("modelSignedCentre", model(1, 1), 32'hFFFF_FFFB);
`else
      checkOutput("modelUnsignedCentre", model(1, 1), 32'h0004_FFFB);
`endif
      runFrame(0, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
      $finish;
   end

endmodule
